// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor
// Receive-side checker for the intersection lamp bus. Each sample strobe
// decodes the six street lamps plus the pedestrian lamp back into a
// controller phase. It checks lamp consistency and phase-sequence legality,
// latches the first fault, counts completed cycles and flags each served
// pedestrian phase.
//
// Optional build macro TLM_PED_WAIT_CHECK_EN adds the ped_req_i input and a
// pending-request latch. With it, a request that was pending when RR2 was
// entered must be served by a PED phase. Otherwise the RR2->GR exit raises
// PED_SKIPPED.

module traffic_light_monitor #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic             clk_i,
  input  logic             reset,
  input  logic             sample_i,
  input  logic             MG_i,
  input  logic             MY_i,
  input  logic             MR_i,
  input  logic             SG_i,
  input  logic             SY_i,
  input  logic             SR_i,
  input  logic             pedLight_i,
  input  logic             clear_fault_i,
`ifdef TLM_PED_WAIT_CHECK_EN
  input  logic             ped_req_i,
`endif
  output logic [2:0]       phase_o,
  output logic             fault_o,
  output logic [2:0]       fault_code_o,
  output logic [CNT_W-1:0] cycle_count_o,
  output logic             ped_served_o
);

  // Phase encoding seen on phase_o
  localparam logic [2:0] PH_GR  = 3'd0;
  localparam logic [2:0] PH_YR  = 3'd1;
  localparam logic [2:0] PH_RR1 = 3'd2;
  localparam logic [2:0] PH_RG  = 3'd3;
  localparam logic [2:0] PH_RY  = 3'd4;
  localparam logic [2:0] PH_RR2 = 3'd5;
  localparam logic [2:0] PH_PED = 3'd6;
  localparam logic [2:0] PH_BAD = 3'd7;

  // Fault codes seen on fault_code_o
  localparam logic [2:0] FC_NONE        = 3'd0;
  localparam logic [2:0] FC_CONFLICT    = 3'd1;
  localparam logic [2:0] FC_PED_LAMP    = 3'd2;
  localparam logic [2:0] FC_ILLEGAL     = 3'd3;
  localparam logic [2:0] FC_STUCK       = 3'd4;
  localparam logic [2:0] FC_PED_SKIPPED = 3'd5;

  // Hold counter saturates one above the limit, so it needs room for MAX_HOLD+1
  localparam int                HOLD_W     = $clog2(MAX_HOLD + 2);
  localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_SAT   = HOLD_W'(MAX_HOLD + 1);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_TRACK,
    ST_FAULT
  } state_e;

  state_e            state_q;
  logic [2:0]        phase_q;
  logic              fault_q;
  logic [2:0]        fault_code_q;
  logic [CNT_W-1:0]  cycle_count_q;
  logic              ped_served_q;
  logic [HOLD_W-1:0] hold_q;

  logic [1:0]        mainCount;
  logic [1:0]        sideCount;
  logic              lampConflict;
  logic              pedLampErr;
  logic [2:0]        phase_d;
  logic              samePhase;
  logic              legalStep;
  logic              holdAtLimit;
  logic [HOLD_W-1:0] hold_d;
  logic              cycleDone;
  logic              pedEntry;
  logic              rr2Exit;
  logic              pedSkipped;
  logic [2:0]        trackCode;

  // Lamp consistency: exactly one lamp per street, never two non-red streets,
  // and the walk lamp only alongside all-red
  always_comb begin
    mainCount    = {1'b0, MG_i} + {1'b0, MY_i} + {1'b0, MR_i};
    sideCount    = {1'b0, SG_i} + {1'b0, SY_i} + {1'b0, SR_i};
    lampConflict = (mainCount != 2'd1) || (sideCount != 2'd1) ||
                   ((MG_i || MY_i) && (SG_i || SY_i));
    pedLampErr   = pedLight_i && (MG_i || MY_i || SG_i || SY_i);
  end

  // Decode the lamps into a phase; all-red needs the previous phase to tell RR1 from RR2
  always_comb begin
    phase_d = PH_BAD;
    if (!(lampConflict || pedLampErr)) begin
      if (MG_i && SR_i) begin
        phase_d = PH_GR;
      end else if (MY_i && SR_i) begin
        phase_d = PH_YR;
      end else if (MR_i && SG_i) begin
        phase_d = PH_RG;
      end else if (MR_i && SY_i) begin
        phase_d = PH_RY;
      end else if (MR_i && SR_i) begin
        if (pedLight_i) begin
          phase_d = PH_PED;
        end else if (phase_q == PH_YR) begin
          phase_d = PH_RR1;
        end else if ((phase_q == PH_RG) || (phase_q == PH_RY) || (phase_q == PH_RR2)) begin
          phase_d = PH_RR2;
        end
      end
    end
  end

  // Phase-sequence legality; repeating the current phase is always a legal step
  always_comb begin
    legalStep = (phase_d == phase_q) && (phase_d != PH_BAD);
    case (phase_q)
      PH_GR:   if (phase_d == PH_YR)  legalStep = 1'b1;
      PH_YR:   if (phase_d == PH_RR1) legalStep = 1'b1;
      PH_RR1:  if (phase_d == PH_RG)  legalStep = 1'b1;
      PH_RG:   if (phase_d == PH_RY)  legalStep = 1'b1;
      PH_RY:   if (phase_d == PH_RR2) legalStep = 1'b1;
      PH_RR2:  if ((phase_d == PH_GR) || (phase_d == PH_PED)) legalStep = 1'b1;
      PH_PED:  if (phase_d == PH_GR)  legalStep = 1'b1;
      default: ;
    endcase
  end

  // Hold counting and the transition events that drive the counters
  always_comb begin
    samePhase   = (phase_d == phase_q);
    holdAtLimit = (hold_q >= HOLD_LIMIT);
    if (!samePhase) begin
      hold_d = HOLD_W'(1);
    end else if (hold_q >= HOLD_SAT) begin
      hold_d = hold_q;
    end else begin
      hold_d = hold_q + HOLD_W'(1);
    end
    cycleDone = (phase_d == PH_GR) && ((phase_q == PH_RR2) || (phase_q == PH_PED));
    pedEntry  = (phase_d == PH_PED) && (phase_q == PH_RR2);
    rr2Exit   = (phase_d == PH_GR) && (phase_q == PH_RR2);
  end

`ifdef TLM_PED_WAIT_CHECK_EN
  logic pedPending_q;
  logic pedAtRr2_q;

  // Pedestrian request latch, plus a snapshot of it taken on entry into RR2
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      pedPending_q <= 1'b0;
      pedAtRr2_q   <= 1'b0;
    end else begin
      if (sample_i && !clear_fault_i) begin
        if ((phase_d == PH_RR2) && (phase_q != PH_RR2)) begin
          pedAtRr2_q <= pedPending_q;
        end
        if ((phase_d == PH_PED) && (phase_q != PH_PED)) begin
          pedPending_q <= 1'b0;
        end
      end
      if (ped_req_i) begin
        pedPending_q <= 1'b1;
      end
    end
  end

  assign pedSkipped = rr2Exit && pedAtRr2_q;
`else
  assign pedSkipped = 1'b0;
`endif

  // First-hit fault selection while tracking, highest priority first
  always_comb begin
    trackCode = FC_NONE;
    if (lampConflict) begin
      trackCode = FC_CONFLICT;
    end else if (pedLampErr) begin
      trackCode = FC_PED_LAMP;
    end else if (!legalStep) begin
      trackCode = FC_ILLEGAL;
    end else if (samePhase && holdAtLimit) begin
      trackCode = FC_STUCK;
    end else if (pedSkipped) begin
      trackCode = FC_PED_SKIPPED;
    end
  end

  // Monitor FSM with all outputs registered; clear_fault beats a coincident sample
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      state_q       <= ST_INIT;
      phase_q       <= PH_BAD;
      fault_q       <= 1'b0;
      fault_code_q  <= FC_NONE;
      cycle_count_q <= '0;
      ped_served_q  <= 1'b0;
      hold_q        <= '0;
    end else begin
      ped_served_q <= 1'b0;
      if (clear_fault_i) begin
        state_q      <= ST_INIT;
        fault_q      <= 1'b0;
        fault_code_q <= FC_NONE;
        hold_q       <= '0;
      end else if (sample_i) begin
        phase_q <= phase_d;
        case (state_q)
          ST_INIT: begin
            hold_q <= HOLD_W'(1);
            if (phase_d == PH_GR) begin
              state_q <= ST_TRACK;
            end else begin
              state_q      <= ST_FAULT;
              fault_q      <= 1'b1;
              fault_code_q <= FC_ILLEGAL;
            end
          end
          ST_TRACK: begin
            hold_q <= hold_d;
            if (trackCode != FC_NONE) begin
              state_q      <= ST_FAULT;
              fault_q      <= 1'b1;
              fault_code_q <= trackCode;
            end
            if (cycleDone) begin
              cycle_count_q <= cycle_count_q + CNT_W'(1);
            end
            if (pedEntry) begin
              ped_served_q <= 1'b1;
            end
          end
          ST_FAULT: begin
            hold_q <= hold_d;
            if (cycleDone) begin
              cycle_count_q <= cycle_count_q + CNT_W'(1);
            end
            if (pedEntry) begin
              ped_served_q <= 1'b1;
            end
          end
          default: begin
            state_q <= ST_INIT;
          end
        endcase
      end
    end
  end

  assign phase_o       = phase_q;
  assign fault_o       = fault_q;
  assign fault_code_o  = fault_code_q;
  assign cycle_count_o = cycle_count_q;
  assign ped_served_o  = ped_served_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Testbench for traffic_light_monitor: directed scenarios plus a randomized
// lamp stream checked against a phase-rule model of the monitor.

module tb_traffic_light_monitor;

  localparam int MAX_HOLD = 8;
  localparam int CNT_W    = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             sample;
  logic             MG, MY, MR, SG, SY, SR, pedLight;
  logic             clearFault;
  logic             pedReq;
  logic [2:0]       phase;
  logic             fault;
  logic [2:0]       faultCode;
  logic [CNT_W-1:0] cycleCount;
  logic             pedServed;

  int testsRun    = 0;
  int testsFailed = 0;

  // Model state
  int               mPhase, mCode, mHold;
  bit               mFault, mStarted, mPedPulse, mPending, mPendAtRr2;
  logic [CNT_W-1:0] mCycles;

  always #5 clk = ~clk;

  traffic_light_monitor #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
    .clk_i        (clk),
    .reset        (reset),
    .sample_i     (sample),
    .MG_i         (MG),
    .MY_i         (MY),
    .MR_i         (MR),
    .SG_i         (SG),
    .SY_i         (SY),
    .SR_i         (SR),
    .pedLight_i   (pedLight),
    .clear_fault_i(clearFault),
`ifdef TLM_PED_WAIT_CHECK_EN
    .ped_req_i    (pedReq),
`endif
    .phase_o      (phase),
    .fault_o      (fault),
    .fault_code_o (faultCode),
    .cycle_count_o(cycleCount),
    .ped_served_o (pedServed)
  );

  // Lamp pattern {MG,MY,MR,SG,SY,SR,ped} that a controller shows in phase p
  function automatic logic [6:0] lampsFor(int p);
    case (p)
      0:       return 7'b100_001_0;
      1:       return 7'b010_001_0;
      2, 5:    return 7'b001_001_0;
      3:       return 7'b001_100_0;
      4:       return 7'b001_010_0;
      6:       return 7'b001_001_1;
      default: return 7'b000_000_0;
    endcase
  endfunction

  // 0 = lamps consistent, 1 = conflict, 2 = walk lamp with a non-red lamp
  function automatic int lampFault(logic [6:0] l);
    logic [2:0] m;
    logic [2:0] s;
    m = l[6:4];
    s = l[3:1];
    if ($countones(m) != 1 || $countones(s) != 1) return 1;
    if (!m[0] && !s[0]) return 1;
    if (l[0] && !(m[0] && s[0])) return 2;
    return 0;
  endfunction

  function automatic int modelDecode(logic [6:0] l, int prev);
    if (lampFault(l) != 0) return 7;
    case (l[6:1])
      6'b100_001: return 0;
      6'b010_001: return 1;
      6'b001_100: return 3;
      6'b001_010: return 4;
      6'b001_001: begin
        if (l[0]) return 6;
        if (prev == 1) return 2;
        if (prev >= 3 && prev <= 5) return 5;
        return 7;
      end
      default: return 7;
    endcase
  endfunction

  // Successor table of the phase cycle: each phase has at most two legal next phases
  function automatic bit modelLegal(int prev, int nxt);
    int succA [7];
    int succB [7];
    succA = '{1, 2, 3, 4, 5, 0, 0};
    succB = '{1, 2, 3, 4, 5, 6, 0};
    if (nxt == 7) return 1'b0;
    if (nxt == prev) return 1'b1;
    if (prev < 0 || prev > 6) return 1'b0;
    return (nxt == succA[prev]) || (nxt == succB[prev]);
  endfunction

  task automatic modelReset();
    mPhase = 7; mCode = 0; mHold = 0; mFault = 0; mStarted = 0;
    mPedPulse = 0; mPending = 0; mPendAtRr2 = 0; mCycles = '0;
  endtask

  task automatic modelStep(input bit doSample, input bit doClear, input logic [6:0] l, input bit req);
    int dec, lf, code, newHold;
    bit same;
    mPedPulse = 0;
    if (doClear) begin
      mStarted = 0; mFault = 0; mCode = 0; mHold = 0;
      mPending = mPending | req;
      return;
    end
    if (!doSample) begin
      mPending = mPending | req;
      return;
    end
    dec     = modelDecode(l, mPhase);
    lf      = lampFault(l);
    same    = (dec == mPhase);
    newHold = same ? ((mHold + 1 > MAX_HOLD + 1) ? MAX_HOLD + 1 : mHold + 1) : 1;
    if (!mFault && !mStarted) begin
      if (dec == 0) mStarted = 1;
      else begin mFault = 1; mCode = 3; end
      mHold = 1;
    end else begin
      if (!mFault) begin
        code = 0;
        if (lf == 1) code = 1;
        else if (lf == 2) code = 2;
        else if (!modelLegal(mPhase, dec)) code = 3;
        else if (same && mHold + 1 > MAX_HOLD) code = 4;
`ifdef TLM_PED_WAIT_CHECK_EN
        else if (mPhase == 5 && dec == 0 && mPendAtRr2) code = 5;
`endif
        if (code != 0) begin mFault = 1; mCode = code; end
      end
      if (dec == 0 && (mPhase == 5 || mPhase == 6)) mCycles = mCycles + 1'b1;
      if (dec == 6 && mPhase == 5) mPedPulse = 1;
      mHold = newHold;
    end
    if (dec == 5 && mPhase != 5) mPendAtRr2 = mPending;
    if (dec == 6 && mPhase != 6) mPending = 0;
    if (req) mPending = 1;
    mPhase = dec;
  endtask

  // Drive one clock of stimulus, then let outputs settle past the edge
  task automatic applyStimulus(input logic doSample, input logic doClear, input logic [6:0] lamps, input logic req);
    @(negedge clk);
    {MG, MY, MR, SG, SY, SR, pedLight} = lamps;
    sample = doSample; clearFault = doClear; pedReq = req;
    @(posedge clk);
    #1;
    sample = 1'b0; clearFault = 1'b0; pedReq = 1'b0;
  endtask

  task automatic samplePhase(int p);
    applyStimulus(1'b1, 1'b0, lampsFor(p), 1'b0);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1; sample = 1'b0; clearFault = 1'b0; pedReq = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    testsRun += 5;
    if (phase !== 3'd7)       begin testsFailed++; $display("[TB] FAIL reset phase: got %0d expected 7", phase); end
    if (fault !== 1'b0)       begin testsFailed++; $display("[TB] FAIL reset fault: got %0d expected 0", fault); end
    if (faultCode !== 3'd0)   begin testsFailed++; $display("[TB] FAIL reset fault_code: got %0d expected 0", faultCode); end
    if (cycleCount !== '0)    begin testsFailed++; $display("[TB] FAIL reset cycle_count: got %0d expected 0", cycleCount); end
    if (pedServed !== 1'b0)   begin testsFailed++; $display("[TB] FAIL reset ped_served: got %0d expected 0", pedServed); end
  endtask

  task automatic test_full_cycle();
    int seq [7];
    seq = '{0, 1, 2, 3, 4, 5, 0};
    doReset();
    for (int i = 0; i < 7; i++) begin
      samplePhase(seq[i]);
      testsRun++;
      if (phase !== 3'(seq[i])) begin
        testsFailed++;
        $display("[TB] FAIL full_cycle phase step %0d: got %0d expected %0d", i, phase, seq[i]);
      end
    end
    testsRun += 2;
    if (cycleCount !== 8'd1) begin testsFailed++; $display("[TB] FAIL full_cycle cycle_count: got %0d expected 1", cycleCount); end
    if (fault !== 1'b0)      begin testsFailed++; $display("[TB] FAIL full_cycle fault: got %0d expected 0", fault); end
  endtask

  task automatic test_ped_phase();
    doReset();
    for (int i = 0; i < 6; i++) samplePhase(i);
    testsRun++;
    if (pedServed !== 1'b0) begin testsFailed++; $display("[TB] FAIL ped_phase early ped_served: got %0d expected 0", pedServed); end
    samplePhase(6);
    testsRun += 2;
    if (phase !== 3'd6)     begin testsFailed++; $display("[TB] FAIL ped_phase phase: got %0d expected 6", phase); end
    if (pedServed !== 1'b1) begin testsFailed++; $display("[TB] FAIL ped_phase pulse: got %0d expected 1", pedServed); end
    applyStimulus(1'b0, 1'b0, lampsFor(6), 1'b0);
    testsRun++;
    if (pedServed !== 1'b0) begin testsFailed++; $display("[TB] FAIL ped_phase pulse width: got %0d expected 0", pedServed); end
    samplePhase(0);
    testsRun += 3;
    if (phase !== 3'd0)      begin testsFailed++; $display("[TB] FAIL ped_phase return phase: got %0d expected 0", phase); end
    if (cycleCount !== 8'd1) begin testsFailed++; $display("[TB] FAIL ped_phase cycle_count: got %0d expected 1", cycleCount); end
    if (fault !== 1'b0)      begin testsFailed++; $display("[TB] FAIL ped_phase fault: got %0d expected 0", fault); end
  endtask

  task automatic test_conflict();
    doReset();
    samplePhase(0);
    applyStimulus(1'b1, 1'b0, 7'b100_100_0, 1'b0);
    testsRun += 3;
    if (fault !== 1'b1)     begin testsFailed++; $display("[TB] FAIL conflict fault: got %0d expected 1", fault); end
    if (faultCode !== 3'd1) begin testsFailed++; $display("[TB] FAIL conflict code: got %0d expected 1", faultCode); end
    if (phase !== 3'd7)     begin testsFailed++; $display("[TB] FAIL conflict phase: got %0d expected 7", phase); end
    samplePhase(1);
    testsRun += 2;
    if (faultCode !== 3'd1) begin testsFailed++; $display("[TB] FAIL conflict frozen code: got %0d expected 1", faultCode); end
    if (phase !== 3'd1)     begin testsFailed++; $display("[TB] FAIL conflict decode in fault: got %0d expected 1", phase); end
    applyStimulus(1'b0, 1'b1, lampsFor(1), 1'b0);
    testsRun += 2;
    if (fault !== 1'b0)     begin testsFailed++; $display("[TB] FAIL conflict clear fault: got %0d expected 0", fault); end
    if (faultCode !== 3'd0) begin testsFailed++; $display("[TB] FAIL conflict clear code: got %0d expected 0", faultCode); end
    // YR followed by GR is only acceptable if the clear returned the monitor to INIT
    samplePhase(0);
    testsRun += 2;
    if (fault !== 1'b0) begin testsFailed++; $display("[TB] FAIL conflict init accept fault: got %0d expected 0", fault); end
    if (phase !== 3'd0) begin testsFailed++; $display("[TB] FAIL conflict init accept phase: got %0d expected 0", phase); end
  endtask

  task automatic test_illegal();
    doReset();
    samplePhase(0);
    samplePhase(3);
    testsRun += 2;
    if (faultCode !== 3'd3) begin testsFailed++; $display("[TB] FAIL illegal code: got %0d expected 3", faultCode); end
    if (fault !== 1'b1)     begin testsFailed++; $display("[TB] FAIL illegal fault: got %0d expected 1", fault); end
  endtask

  task automatic test_stuck();
    doReset();
    for (int i = 0; i < MAX_HOLD; i++) samplePhase(0);
    testsRun++;
    if (fault !== 1'b0) begin testsFailed++; $display("[TB] FAIL stuck early fault after %0d samples: got %0d expected 0", MAX_HOLD, fault); end
    samplePhase(0);
    testsRun += 2;
    if (fault !== 1'b1)     begin testsFailed++; $display("[TB] FAIL stuck fault: got %0d expected 1", fault); end
    if (faultCode !== 3'd4) begin testsFailed++; $display("[TB] FAIL stuck code: got %0d expected 4", faultCode); end
  endtask

  task automatic test_clear_priority();
    doReset();
    samplePhase(0);
    applyStimulus(1'b1, 1'b0, 7'b110_001_0, 1'b0);
    applyStimulus(1'b1, 1'b1, lampsFor(0), 1'b0);
    testsRun += 2;
    if (phase !== 3'd7) begin testsFailed++; $display("[TB] FAIL clear_priority phase: got %0d expected 7", phase); end
    if (fault !== 1'b0) begin testsFailed++; $display("[TB] FAIL clear_priority fault: got %0d expected 0", fault); end
    samplePhase(0);
    testsRun += 2;
    if (phase !== 3'd0) begin testsFailed++; $display("[TB] FAIL clear_priority next phase: got %0d expected 0", phase); end
    if (fault !== 1'b0) begin testsFailed++; $display("[TB] FAIL clear_priority next fault: got %0d expected 0", fault); end
  endtask

  task automatic test_reset_mid();
    doReset();
    for (int i = 0; i < 5; i++) samplePhase(i);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    testsRun += 4;
    if (phase !== 3'd7)     begin testsFailed++; $display("[TB] FAIL reset_mid phase: got %0d expected 7", phase); end
    if (cycleCount !== '0)  begin testsFailed++; $display("[TB] FAIL reset_mid cycle_count: got %0d expected 0", cycleCount); end
    if (fault !== 1'b0)     begin testsFailed++; $display("[TB] FAIL reset_mid fault: got %0d expected 0", fault); end
    if (faultCode !== 3'd0) begin testsFailed++; $display("[TB] FAIL reset_mid code: got %0d expected 0", faultCode); end
    @(negedge clk);
    reset = 1'b0;
    samplePhase(0);
    testsRun += 2;
    if (phase !== 3'd0) begin testsFailed++; $display("[TB] FAIL reset_mid restart phase: got %0d expected 0", phase); end
    if (fault !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_mid restart fault: got %0d expected 0", fault); end
  endtask

  task automatic test_ped_wait();
    doReset();
    for (int i = 0; i < 4; i++) samplePhase(i);
    applyStimulus(1'b0, 1'b0, lampsFor(3), 1'b1);
    samplePhase(4);
    samplePhase(5);
    samplePhase(0);
`ifdef TLM_PED_WAIT_CHECK_EN
    testsRun += 2;
    if (fault !== 1'b1)     begin testsFailed++; $display("[TB] FAIL ped_wait fault: got %0d expected 1", fault); end
    if (faultCode !== 3'd5) begin testsFailed++; $display("[TB] FAIL ped_wait code: got %0d expected 5", faultCode); end
`else
    testsRun += 2;
    if (fault !== 1'b0)      begin testsFailed++; $display("[TB] FAIL ped_wait fault: got %0d expected 0", fault); end
    if (cycleCount !== 8'd1) begin testsFailed++; $display("[TB] FAIL ped_wait cycle_count: got %0d expected 1", cycleCount); end
`endif
  endtask

  task automatic test_random();
    int r, nxt;
    bit doS, doC, req;
    logic [6:0] lamps;
    doReset();
    modelReset();
    for (int n = 0; n < 800; n++) begin
      r     = $urandom_range(0, 99);
      req   = ($urandom_range(0, 9) == 0);
      doS   = 1'b1;
      doC   = 1'b0;
      if (mFault && r < 30) begin
        doC   = 1'b1;
        doS   = 1'($urandom_range(0, 1));
        lamps = lampsFor(0);
      end else if (r < 70) begin
        if (mPhase >= 0 && mPhase <= 4) nxt = mPhase + 1;
        else if (mPhase == 5) nxt = ($urandom_range(0, 1) == 0) ? 0 : 6;
        else nxt = 0;
        lamps = lampsFor(nxt);
      end else if (r < 80) begin
        lamps = lampsFor((mPhase > 6) ? 0 : mPhase);
      end else if (r < 88) begin
        lamps = lampsFor($urandom_range(0, 6));
      end else if (r < 94) begin
        lamps = 7'($urandom_range(0, 127));
      end else begin
        doS   = 1'b0;
        lamps = 7'($urandom_range(0, 127));
      end
      applyStimulus(doS, doC, lamps, req);
      modelStep(doS, doC, lamps, req);
      testsRun += 5;
      if (phase !== 3'(mPhase))     begin testsFailed++; $display("[TB] FAIL random phase step %0d: got %0d expected %0d", n, phase, mPhase); end
      if (fault !== mFault)         begin testsFailed++; $display("[TB] FAIL random fault step %0d: got %0d expected %0d", n, fault, mFault); end
      if (faultCode !== 3'(mCode))  begin testsFailed++; $display("[TB] FAIL random code step %0d: got %0d expected %0d", n, faultCode, mCode); end
      if (cycleCount !== mCycles)   begin testsFailed++; $display("[TB] FAIL random cycle_count step %0d: got %0d expected %0d", n, cycleCount, mCycles); end
      if (pedServed !== mPedPulse)  begin testsFailed++; $display("[TB] FAIL random ped_served step %0d: got %0d expected %0d", n, pedServed, mPedPulse); end
    end
  endtask

  // Guard against a hung run
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Scenario sequence
  initial begin
    reset = 1'b1; sample = 1'b0; clearFault = 1'b0; pedReq = 1'b0;
    {MG, MY, MR, SG, SY, SR, pedLight} = 7'b0;
    test_reset();
    test_full_cycle();
    test_ped_phase();
    test_conflict();
    test_illegal();
    test_stuck();
    test_clear_priority();
    test_reset_mid();
    test_ped_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
